branch_update_queue: RTL and testbench
======================================

# branch_update_queue

Buffers resolved-branch results from the execute stage and drains them, one per cycle, into the branch cache's jump/update port (iJUMP_STB / iJUMP_VALID / iJUMP_ADDR / iJUMP_INST_ADDR). It decouples execute-stage branch resolution bursts from the cache's single write port. It also allows the fetch side to hold training writes off for a cycle when a search must win.

## Interface
- DEPTH_N, 2: log2 of queue depth; depth = 2^DEPTH_N entries (default 4).
- iCLOCK  in  1  clock, all state on rising edge.
- inRESET  in  1  reset, asynchronous, active-low.
- iFLUSH  in  1  synchronous flush; empties the queue.
- iRESULT_VALID  in  1  resolved branch present this cycle.
- iRESULT_TAKEN  in  1  1 = branch was taken.
- iRESULT_INST_ADDR  in  32  address of the branch instruction.
- iRESULT_JUMP_ADDR  in  32  resolved target address.
- oRESULT_LOCK  out  1  1 = queue cannot accept a push this cycle.
- iDRAIN_HOLD  in  1  1 = do not present or pop the head this cycle.
- oJUMP_STB  out  1  update strobe to branch cache.
- oJUMP_VALID  out  1  taken flag of head entry.
- oJUMP_ADDR  out  32  target of head entry.
- oJUMP_INST_ADDR  out  32  instruction address of head entry.
- oDROP_COUNT  out  8  saturating count of dropped results (0 unless BRANCH_UPDATE_QUEUE_DROP_EN).

## Operation
- Circular buffer of 2^DEPTH_N entries {taken, inst_addr[31:0], jump_addr[31:0]}; write pointer, read pointer (DEPTH_N bits, natural wrap), occupancy count (DEPTH_N+1 bits).
- full = (count == 2^DEPTH_N); empty = (count == 0).
- push = iRESULT_VALID && !full && !iFLUSH; entry written at write pointer, pointer +1.
- oJUMP_STB = !empty && !iDRAIN_HOLD (combinational); oJUMP_VALID/ADDR/INST_ADDR = head entry fields, driven regardless of STB.
- pop = oJUMP_STB && !iFLUSH; read pointer +1. The cache always accepts; there is no cache-side back-pressure.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push while full is not accepted even if a pop occurs the same cycle. Full status is taken from the registered count.
- No fall-through: an entry pushed in cycle N is first visible on oJUMP_* in cycle N+1.
- Order is strictly FIFO. Results are never merged or reordered; each push produces exactly one oJUMP_STB pulse.
- iFLUSH: next edge sets pointers and count to 0. A push and pop in the flush cycle are discarded. oJUMP_STB still reflects pre-flush head during that cycle. The cache flushes in the same cycle, so the write is ignored by design.
- oDROP_COUNT is not cleared by iFLUSH.

## Timing
- Reset values: pointers 0, count 0, oJUMP_STB 0, oRESULT_LOCK 0, oDROP_COUNT 0. oJUMP_VALID/ADDR/INST_ADDR reflect uninitialised entry 0; they are don't-care while oJUMP_STB = 0.
- Reset asserted mid-operation discards all entries immediately (asynchronous).
- Push-to-strobe latency: 1 cycle minimum, plus one cycle per older entry, plus one cycle per iDRAIN_HOLD cycle.
- Throughput: 1 push and 1 pop per cycle sustained when not full.
- oRESULT_LOCK is a combinational function of registered count only; it does not depend on iDRAIN_HOLD or iRESULT_VALID.

## Configuration
- BRANCH_UPDATE_QUEUE_DROP_EN defined:
  - oRESULT_LOCK is tied to 0 and execute never stalls.
  - A result arriving while full is discarded and oDROP_COUNT increments, saturating at 8'hFF.
  - Queue contents are unaffected by the drop.
- Not defined:
  - oRESULT_LOCK = full.
  - A push attempted while full is ignored (protocol violation) and oDROP_COUNT stays 0.

## Test plan
- Reset, then push 3 results (inst 0x100/0x104/0x108, taken 1/0/1), no hold -> oJUMP_STB high cycles 1-3 after first push, INST_ADDR 0x100, 0x104, 0x108 in order with VALID 1,0,1; empty afterwards, STB 0.
- Hold iDRAIN_HOLD=1 and push 4 results -> count 4, oRESULT_LOCK=1 (macro off), oJUMP_STB=0. A 5th push is ignored. Release hold -> exactly 4 strobes.
- Full queue with hold released: assert push and pop same cycle -> push rejected, count goes 4->3, lock deasserts next cycle.
- Queue with 2 entries, assert iFLUSH together with push -> next cycle count 0, STB 0. A subsequent push of 0x200 is the next strobed entry.
- With BRANCH_UPDATE_QUEUE_DROP_EN: fill 4 under hold, push 300 more -> lock stays 0, oDROP_COUNT = 0xFF, and the original 4 entries drain intact.
- Pointer wrap: push/pop 10 entries back-to-back, depth 4 -> all 10 strobed in order with correct addresses, no loss across wrap.

Source files
------------

// File: rtl/branch_update_queue_if.sv
// Execute-side result port and cache-side jump/update port of branch_update_queue.
// The producer/consumer environment drives master; the queue itself is the slave.
interface branch_update_queue_if;
    logic        iRESULT_VALID;
    logic        iRESULT_TAKEN;
    logic [31:0] iRESULT_INST_ADDR;
    logic [31:0] iRESULT_JUMP_ADDR;
    logic        oRESULT_LOCK;
    logic        iDRAIN_HOLD;
    logic        oJUMP_STB;
    logic        oJUMP_VALID;
    logic [31:0] oJUMP_ADDR;
    logic [31:0] oJUMP_INST_ADDR;

    modport master (
        output iRESULT_VALID, iRESULT_TAKEN, iRESULT_INST_ADDR, iRESULT_JUMP_ADDR,
        output iDRAIN_HOLD,
        input  oRESULT_LOCK, oJUMP_STB, oJUMP_VALID, oJUMP_ADDR, oJUMP_INST_ADDR
    );

    modport slave (
        input  iRESULT_VALID, iRESULT_TAKEN, iRESULT_INST_ADDR, iRESULT_JUMP_ADDR,
        input  iDRAIN_HOLD,
        output oRESULT_LOCK, oJUMP_STB, oJUMP_VALID, oJUMP_ADDR, oJUMP_INST_ADDR
    );
endinterface

// File: rtl/branch_update_queue.sv
// FIFO of resolved branches drained one per cycle into the branch cache update port.
// Define BRANCH_UPDATE_QUEUE_DROP_EN to drop (and count) results arriving while full instead of locking.
module branch_update_queue #(
    parameter int DEPTH_N = 2
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  iFLUSH,
    branch_update_queue_if.slave  bus,
    output logic [7:0]            oDROP_COUNT
);
    localparam int                DEPTH      = 1 << DEPTH_N;
    localparam logic [DEPTH_N:0]  COUNT_FULL = (DEPTH_N + 1)'(DEPTH);

    typedef struct packed {
        logic        taken;
        logic [31:0] inst_addr;
        logic [31:0] jump_addr;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_N:0]   count_q, count_d;
    logic               full, empty, push, pop;
    entry_t             head;

    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);
    assign push  = bus.iRESULT_VALID && !full && !iFLUSH;
    assign pop   = bus.oJUMP_STB && !iFLUSH;
    assign head  = mem[rd_ptr_q];

    assign bus.oJUMP_STB       = !empty && !bus.iDRAIN_HOLD;
    assign bus.oJUMP_VALID     = head.taken;
    assign bus.oJUMP_ADDR      = head.jump_addr;
    assign bus.oJUMP_INST_ADDR = head.inst_addr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iFLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge iCLOCK) begin
        if (push) begin
            mem[wr_ptr_q] <= '{taken:     bus.iRESULT_TAKEN,
                               inst_addr: bus.iRESULT_INST_ADDR,
                               jump_addr: bus.iRESULT_JUMP_ADDR};
        end
    end

`ifdef BRANCH_UPDATE_QUEUE_DROP_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (bus.iRESULT_VALID && full && !iFLUSH && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    // Flush deliberately leaves the drop statistic intact.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) drop_q <= '0;
        else          drop_q <= drop_d;
    end

    assign bus.oRESULT_LOCK = 1'b0;
    assign oDROP_COUNT      = drop_q;
`else
    assign bus.oRESULT_LOCK = full;
    assign oDROP_COUNT      = 8'h00;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed self-checking bench for branch_update_queue (depth 4); inputs and checks at the falling edge.
module tb_branch_update_queue;
    logic       iCLOCK  = 1'b0;
    logic       inRESET = 1'b1;
    logic       iFLUSH  = 1'b0;
    logic [7:0] oDROP_COUNT;
    int         checks  = 0;
    int         errors  = 0;
    int         exp_drop = 0;

`ifdef BRANCH_UPDATE_QUEUE_DROP_EN
    localparam logic LOCK_WHEN_FULL = 1'b0;
    localparam bit   DROP_EN        = 1'b1;
`else
    localparam logic LOCK_WHEN_FULL = 1'b1;
    localparam bit   DROP_EN        = 1'b0;
`endif

    branch_update_queue_if bus ();

    branch_update_queue #(.DEPTH_N(2)) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iFLUSH      (iFLUSH),
        .bus         (bus),
        .oDROP_COUNT (oDROP_COUNT)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // One cycle: drive inputs on the falling edge, let combinational outputs settle.
    task automatic cyc(input logic v, input logic tk, input logic [31:0] inst,
                       input logic hold, input logic fl);
        @(negedge iCLOCK);
        bus.iRESULT_VALID     = v;
        bus.iRESULT_TAKEN     = tk;
        bus.iRESULT_INST_ADDR = inst;
        bus.iRESULT_JUMP_ADDR = inst + 32'h1000;
        bus.iDRAIN_HOLD       = hold;
        iFLUSH                = fl;
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] inst, input logic tk);
        check_eq({tag, "_stb"},   64'(bus.oJUMP_STB),       64'(1'b1));
        check_eq({tag, "_inst"},  64'(bus.oJUMP_INST_ADDR), 64'(inst));
        check_eq({tag, "_jump"},  64'(bus.oJUMP_ADDR),      64'(inst + 32'h1000));
        check_eq({tag, "_taken"}, 64'(bus.oJUMP_VALID),     64'(tk));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_stb"}, 64'(bus.oJUMP_STB), 64'(1'b0));
    endtask

    initial begin
        bus.iRESULT_VALID     = 1'b0;
        bus.iRESULT_TAKEN     = 1'b0;
        bus.iRESULT_INST_ADDR = '0;
        bus.iRESULT_JUMP_ADDR = '0;
        bus.iDRAIN_HOLD       = 1'b0;
        #1 inRESET = 1'b0;
        #1;
        check_eq("rst_stb",  64'(bus.oJUMP_STB),    64'(1'b0));
        check_eq("rst_lock", 64'(bus.oRESULT_LOCK), 64'(1'b0));
        check_eq("rst_drop", 64'(oDROP_COUNT),      64'(8'h00));
        @(negedge iCLOCK);
        inRESET = 1'b1;

        // Three pushes, no hold: each head appears one cycle after its push.
        cyc(1, 1, 32'h100, 0, 0); check_idle("t1_c0");
        cyc(1, 0, 32'h104, 0, 0); check_head("t1_c1", 32'h100, 1'b1);
        cyc(1, 1, 32'h108, 0, 0); check_head("t1_c2", 32'h104, 1'b0);
        cyc(0, 0, 32'h0,   0, 0); check_head("t1_c3", 32'h108, 1'b1);
        cyc(0, 0, 32'h0,   0, 0); check_idle("t1_c4");

        // Fill under hold; fifth push is refused.
        for (int i = 0; i < 4; i++) begin
            cyc(1, i[0], 32'h300 + 32'(i * 4), 1, 0);
            check_eq("t2_lock_fill", 64'(bus.oRESULT_LOCK), 64'(1'b0));
            check_idle("t2_fill");
        end
        cyc(1, 0, 32'h3F0, 1, 0);
        check_eq("t2_lock_full", 64'(bus.oRESULT_LOCK), 64'(LOCK_WHEN_FULL));
        check_idle("t2_held");
        if (DROP_EN) exp_drop++;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 32'h0, 0, 0);
            check_head("t2_drain", 32'h300 + 32'(i * 4), i[0]);
        end
        cyc(0, 0, 32'h0, 0, 0); check_idle("t2_empty");
        check_eq("t2_drop", 64'(oDROP_COUNT), 64'(exp_drop));

        // Full with drain released: simultaneous push/pop rejects the push.
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h400 + 32'(i * 4), 1, 0);
        cyc(1, 1, 32'h4FF, 0, 0);
        check_head("t3_pp", 32'h400, 1'b0);
        check_eq("t3_lock_full", 64'(bus.oRESULT_LOCK), 64'(LOCK_WHEN_FULL));
        if (DROP_EN) exp_drop++;
        cyc(0, 0, 32'h0, 0, 0);
        check_eq("t3_lock_after", 64'(bus.oRESULT_LOCK), 64'(1'b0));
        check_head("t3_d1", 32'h404, 1'b0);
        cyc(0, 0, 32'h0, 0, 0); check_head("t3_d2", 32'h408, 1'b0);
        cyc(0, 0, 32'h0, 0, 0); check_head("t3_d3", 32'h40C, 1'b0);
        cyc(0, 0, 32'h0, 0, 0); check_idle("t3_empty");
        check_eq("t3_drop", 64'(oDROP_COUNT), 64'(exp_drop));

        // Flush with a concurrent push discards everything.
        cyc(1, 0, 32'h600, 1, 0);
        cyc(1, 0, 32'h604, 1, 0);
        cyc(1, 1, 32'h6FF, 0, 1); check_head("t4_flushcyc", 32'h600, 1'b0);
        cyc(1, 1, 32'h200, 0, 0); check_idle("t4_after");
        cyc(0, 0, 32'h0,   0, 0); check_head("t4_next", 32'h200, 1'b1);
        cyc(0, 0, 32'h0,   0, 0); check_idle("t4_empty");
        check_eq("t4_drop_kept", 64'(oDROP_COUNT), 64'(exp_drop));

`ifdef BRANCH_UPDATE_QUEUE_DROP_EN
        // Saturating drop counter; queued entries survive the overflow burst.
        for (int i = 0; i < 4; i++) cyc(1, 1, 32'h700 + 32'(i * 4), 1, 0);
        for (int i = 0; i < 300; i++) cyc(1, 0, 32'h7FF, 1, 0);
        check_eq("t5_lock", 64'(bus.oRESULT_LOCK), 64'(1'b0));
        cyc(0, 0, 32'h0, 1, 0);
        exp_drop = 255;
        check_eq("t5_drop_sat", 64'(oDROP_COUNT), 64'(exp_drop));
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 32'h0, 0, 0);
            check_head("t5_drain", 32'h700 + 32'(i * 4), 1'b1);
        end
        cyc(0, 0, 32'h0, 0, 0); check_idle("t5_empty");
`endif

        // Back-to-back push/pop across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            cyc(1, k[1], 32'hA00 + 32'(k * 4), 0, 0);
            if (k == 0) check_idle("t6_first");
            else        check_head("t6_wrap", 32'hA00 + 32'((k - 1) * 4), 1'(((k - 1) >> 1) & 1));
        end
        cyc(0, 0, 32'h0, 0, 0); check_head("t6_last", 32'hA24, 1'b0);
        cyc(0, 0, 32'h0, 0, 0); check_idle("t6_empty");

        // Asynchronous reset mid-operation empties the queue immediately.
        cyc(1, 0, 32'h800, 1, 0);
        cyc(1, 0, 32'h804, 1, 0);
        cyc(0, 0, 32'h0,   0, 0); check_head("t7_pre", 32'h800, 1'b0);
        inRESET = 1'b0;
        #1;
        check_idle("t7_async");
        check_eq("t7_drop", 64'(oDROP_COUNT), 64'(8'h00));
        @(negedge iCLOCK);
        inRESET = 1'b1;
        cyc(0, 0, 32'h0, 0, 0); check_idle("t7_after");
        check_eq("t7_lock", 64'(bus.oRESULT_LOCK), 64'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
